hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the 8-register pipelined core: the stall/flush side of hazard resolution, complementing operand forwarding. It detects load-use hazards that forwarding cannot cover, holds the front end and EX stage for multi-cycle multiplies, and flushes wrong-path instructions on a taken branch. It drives the PC, IF/ID, ID/EX and EX pipeline-register controls from a small FSM plus a multiply cycle counter.

## Interface
Parameters:
- REG_W, 3, register-address width (8 architectural registers; register 0 is hardwired zero)
- MUL_CYCLES, 4, cycles a multiply occupies EX; legal range 2..16

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_RegRt  in  REG_W  destination of the load in EX
- IFID_RegRs  in  REG_W  rs source of the instruction in ID
- IFID_RegRt  in  REG_W  rt source of the instruction in ID
- IFID_UsesRt  in  1  instruction in ID reads rt as a source (not as a destination)
- Mul_Start  in  1  a multiply is in its first EX cycle
- Branch_Taken  in  1  branch in EX resolved taken this cycle
- PCWrite  out  1  PC may update
- IFID_Write  out  1  IF/ID may load
- IFID_Flush  out  1  IF/ID loads a NOP
- IDEX_Bubble  out  1  ID/EX loads a NOP (control bits zeroed)
- EX_Hold  out  1  ID/EX and EX/MEM hold; EX/MEM inserts no new result

## Operation
- Outputs are Mealy: combinational from state, counter and inputs, so the response lands in the same cycle as the hazard.
- Default (no action): PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, EX_Hold=0.
- load_use = IDEX_MemRead & (IDEX_RegRt != 0) & ((IDEX_RegRt == IFID_RegRs) | (IFID_UsesRt & IDEX_RegRt == IFID_RegRt)).
- States: RUN, LOAD_STALL, MUL_BUSY. A 4-bit counter `cnt` is used only in MUL_BUSY.
- RUN priority: Branch_Taken > Mul_Start > load_use.
  - Branch_Taken: IFID_Flush=1 and IDEX_Bubble=1; PC loads the target; stay in RUN.
  - Mul_Start: PCWrite=0, IFID_Write=0, EX_Hold=1.
    - MUL_CYCLES==2: next state RUN.
    - Otherwise: cnt <= MUL_CYCLES-2; next state MUL_BUSY.
  - load_use: PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next state LOAD_STALL.
- LOAD_STALL:
  - Default outputs; load_use and Mul_Start are ignored because EX holds the bubble.
  - Branch_Taken is honoured as in RUN.
  - Next state is always RUN, giving exactly one stall cycle per load-use.
- MUL_BUSY:
  - PCWrite=0, IFID_Write=0, EX_Hold=1.
  - Branch_Taken, Mul_Start and load_use are ignored.
  - cnt==1: next state RUN. Otherwise cnt <= cnt-1.
- Reset: while rst=1, outputs are default values. On the next edge, state=RUN and cnt=0. A reset in MUL_BUSY or LOAD_STALL abandons the sequence with no residual stall.

## Timing
- Load-use: 1 bubble cycle. The dependent instruction reaches EX one cycle later and receives the loaded value via MEM/WB forwarding.
- Multiply: EX_Hold is high for exactly MUL_CYCLES-1 consecutive cycles, starting with the Mul_Start cycle. In the MUL_CYCLES-th cycle, hold is released and the product advances.
- Taken branch: 2-cycle penalty, with IF/ID and ID/EX flushed in the same cycle.
- Branch_Taken and load_use in the same cycle: the flush wins; no LOAD_STALL is entered because the dependent instruction is discarded.
- State and cnt update only on the rising edge of clk; there is no asynchronous path.

## Structure
- Shared package holds:
  - the state encodings RUN=2'b00, LOAD_STALL=2'b01, MUL_BUSY=2'b10
  - REG_W
  - the NOP/bubble control constant used by the IF/ID and ID/EX registers
- One sub-module, hazard_mul_counter:
  - loadable 4-bit down-counter with a `last` flag (cnt==1)
  - instantiated once
- The FSM and output decode live in hazard_stall_unit.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_RegRt=3, IFID_RegRs=3 -> one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; the following cycle has default outputs.
- Register 0 and rt gating:
  - IDEX_RegRt=0 matching IFID_RegRs=0 -> no stall.
  - IDEX_RegRt=5, IFID_RegRt=5, IFID_UsesRt=0 -> no stall.
- Multiply, MUL_CYCLES=4: Mul_Start pulse -> EX_Hold=1 for exactly 3 cycles, then 0. Branch_Taken=1 in the second hold cycle -> no flush.
- Multiply, MUL_CYCLES=2: Mul_Start -> EX_Hold high for exactly 1 cycle; state never enters MUL_BUSY.
- Branch_Taken=1 together with load_use in RUN -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; next cycle has default outputs.
- rst=1 during the second MUL_BUSY cycle -> outputs are default while rst=1; after release, state=RUN and a new load_use stalls exactly one cycle.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared state encodings, widths and bubble constant for hazard control
package hazard_stall_unit_pkg;
  localparam int REG_W = 3;
  localparam int CNT_W = 4;
  localparam logic [7:0] NOP_CTRL = 8'h00;
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MUL_BUSY   = 2'b10
  } state_t;
endpackage

// File: rtl/hazard_stall_unit_mul_counter.sv
// hazard_mul_counter: loadable down-counter timing the remaining multiply hold cycles
module hazard_mul_counter
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, multiply hold and taken-branch flush control
module hazard_stall_unit #(
  parameter int REG_W      = hazard_stall_unit_pkg::REG_W,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_RegRt,
  input  logic [REG_W-1:0] IFID_RegRs,
  input  logic [REG_W-1:0] IFID_RegRt,
  input  logic             IFID_UsesRt,
  input  logic             Mul_Start,
  input  logic             Branch_Taken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EX_Hold
);
  import hazard_stall_unit_pkg::*;
  state_t state, next;
  logic load_use, pcw, ifw, fl, bub, hold, cnt_load, dec, last;
  logic [CNT_W-1:0] cnt;
  assign load_use = IDEX_MemRead && IDEX_RegRt != '0 &&
                    (IDEX_RegRt == IFID_RegRs || (IFID_UsesRt && IDEX_RegRt == IFID_RegRt));
  hazard_mul_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .load(cnt_load),
    .load_val(CNT_W'(MUL_CYCLES - 2)),
    .dec(dec),
    .cnt(cnt),
    .last(last)
  );
  always_comb begin
    next = state;
    pcw = 1'b1;
    ifw = 1'b1;
    fl = 1'b0;
    bub = 1'b0;
    hold = 1'b0;
    cnt_load = 1'b0;
    dec = 1'b0;
    case (state)
      RUN:
        if (Branch_Taken) begin
          fl = 1'b1;
          bub = 1'b1;
        end else if (Mul_Start) begin
          pcw = 1'b0;
          ifw = 1'b0;
          hold = 1'b1;
          if (MUL_CYCLES != 2) begin
            cnt_load = 1'b1;
            next = MUL_BUSY;
          end
        end else if (load_use) begin
          pcw = 1'b0;
          ifw = 1'b0;
          bub = 1'b1;
          next = LOAD_STALL;
        end
      LOAD_STALL: begin
        next = RUN;
        fl = Branch_Taken;
        bub = Branch_Taken;
      end
      MUL_BUSY: begin
        pcw = 1'b0;
        ifw = 1'b0;
        hold = 1'b1;
        dec = 1'b1;
        next = last ? RUN : MUL_BUSY;
      end
      default: next = RUN;
    endcase
  end
  // Reset forces the no-action response so an abandoned sequence leaves no stall behind
  assign PCWrite     = rst | pcw;
  assign IFID_Write  = rst | ifw;
  assign IFID_Flush  = ~rst & fl;
  assign IDEX_Bubble = ~rst & bub;
  assign EX_Hold     = ~rst & hold;
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= next;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench driving MUL_CYCLES=4 and MUL_CYCLES=2 instances in lockstep
module tb_hazard_stall_unit;
  typedef struct {
    string      name;
    logic [4:0] e4;
    logic [4:0] e2;
  } exp_t;
  localparam logic [4:0] D = 5'b11000;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] H = 5'b00001;
  localparam logic [4:0] F = 5'b11110;
  logic clk = 1'b0;
  logic rst, mr, ut, ms, bt;
  logic [2:0] ert, rs, rt;
  logic pcw4, ifw4, fl4, bub4, hold4;
  logic pcw2, ifw2, fl2, bub2, hold2;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  hazard_stall_unit #(.REG_W(3), .MUL_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_RegRt(ert), .IFID_RegRs(rs),
    .IFID_RegRt(rt), .IFID_UsesRt(ut), .Mul_Start(ms), .Branch_Taken(bt),
    .PCWrite(pcw4), .IFID_Write(ifw4), .IFID_Flush(fl4), .IDEX_Bubble(bub4), .EX_Hold(hold4)
  );
  hazard_stall_unit #(.REG_W(3), .MUL_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_RegRt(ert), .IFID_RegRs(rs),
    .IFID_RegRt(rt), .IFID_UsesRt(ut), .Mul_Start(ms), .Branch_Taken(bt),
    .PCWrite(pcw2), .IFID_Write(ifw2), .IFID_Flush(fl2), .IDEX_Bubble(bub2), .EX_Hold(hold2)
  );
  always @(negedge clk)
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      automatic logic [4:0] a4 = {pcw4, ifw4, fl4, bub4, hold4};
      automatic logic [4:0] a2 = {pcw2, ifw2, fl2, bub2, hold2};
      checks++;
      if (a4 !== e.e4) begin
        errors++;
        $display("FAIL %s mul4 got %b want %b", e.name, a4, e.e4);
      end
      checks++;
      if (a2 !== e.e2) begin
        errors++;
        $display("FAIL %s mul2 got %b want %b", e.name, a2, e.e2);
      end
    end
  task automatic apply(input string name, input logic r, input logic m, input logic [2:0] er,
                       input logic [2:0] s, input logic [2:0] t, input logic u, input logic mul,
                       input logic br, input logic [4:0] e4, input logic [4:0] e2);
    @(posedge clk);
    #1;
    rst = r; mr = m; ert = er; rs = s; rt = t; ut = u; ms = mul; bt = br;
    q.push_back('{name, e4, e2});
  endtask
  initial begin
    rst = 1'b1; mr = 1'b0; ert = '0; rs = '0; rt = '0; ut = 1'b0; ms = 1'b0; bt = 1'b0;
    apply("reset",          1, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("reset_lu",       1, 1, 3, 3, 0, 0, 0, 0, D, D);
    apply("idle",           0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("lu_rs",          0, 1, 3, 3, 0, 0, 0, 0, L, L);
    apply("lu_stall_once",  0, 1, 3, 3, 0, 0, 0, 0, D, D);
    apply("idle2",          0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("r0_nostall",     0, 1, 0, 0, 0, 0, 0, 0, D, D);
    apply("rt_unused",      0, 1, 5, 1, 5, 0, 0, 0, D, D);
    apply("rt_used",        0, 1, 5, 1, 5, 1, 0, 0, L, L);
    apply("after_rt_stall", 0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("mul_start",      0, 0, 0, 0, 0, 0, 1, 0, H, H);
    apply("mul_busy_br",    0, 0, 0, 0, 0, 0, 0, 1, H, F);
    apply("mul_busy_last",  0, 0, 0, 0, 0, 0, 0, 0, H, D);
    apply("mul_release",    0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("br_vs_lu",       0, 1, 3, 3, 0, 0, 0, 1, F, F);
    apply("after_br",       0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("mul_start2",     0, 0, 0, 0, 0, 0, 1, 0, H, H);
    apply("mul_busy_1st",   0, 0, 0, 0, 0, 0, 0, 0, H, D);
    apply("rst_in_busy",    1, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("lu_after_rst",   0, 1, 3, 3, 0, 0, 0, 0, L, L);
    apply("lu_after_rst2",  0, 1, 3, 3, 0, 0, 0, 0, D, D);
    apply("idle3",          0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("lu_again",       0, 1, 6, 6, 0, 0, 0, 0, L, L);
    apply("stall_br",       0, 1, 6, 6, 0, 0, 0, 1, F, F);
    apply("idle4",          0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("lu_rt7",         0, 1, 7, 2, 7, 1, 0, 0, L, L);
    apply("stall_mul_ign",  0, 0, 0, 0, 0, 0, 1, 0, D, D);
    apply("idle5",          0, 0, 0, 0, 0, 0, 0, 0, D, D);
    apply("br_vs_mul",      0, 0, 0, 0, 0, 0, 1, 1, F, F);
    apply("after_br_mul",   0, 0, 0, 0, 0, 0, 0, 0, D, D);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
